// File: rtl/minized_led_breather_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : minized_led_pkg
//  Description : Shared phase encoding and phase-classification helpers for
//                the MiniZed bicolor LED breathing driver.
//  Revision    : 1.0 - initial release
// ============================================================================
package minized_led_pkg;

    localparam int c_PHASE_W = 3;

    // Sequence phases; codes 6 and 7 are unused and treated as illegal
    typedef enum logic [c_PHASE_W-1:0] {
        G_UP  = 3'd0,
        G_DN  = 3'd1,
        G_OFF = 3'd2,
        R_UP  = 3'd3,
        R_DN  = 3'd4,
        R_OFF = 3'd5
    } led_phase_t;

    // True while a colour is being ramped up or down
    function automatic logic is_ramp(input logic [c_PHASE_W-1:0] phase);
        return (phase == G_UP) || (phase == G_DN) ||
               (phase == R_UP) || (phase == R_DN);
    endfunction

    // True during the dark gap between colours
    function automatic logic is_off(input logic [c_PHASE_W-1:0] phase);
        return (phase == G_OFF) || (phase == R_OFF);
    endfunction

    // True while the green channel owns the LED
    function automatic logic is_green(input logic [c_PHASE_W-1:0] phase);
        return (phase == G_UP) || (phase == G_DN);
    endfunction

    // True while the red channel owns the LED
    function automatic logic is_red(input logic [c_PHASE_W-1:0] phase);
        return (phase == R_UP) || (phase == R_DN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/minized_led_breather_if.sv
`default_nettype none
// ============================================================================
//  Module      : minized_led_breather_if
//  Description : Control and LED/debug signal bundle of the breathing driver.
//                The slave side is the driver, the master side its user.
//  Revision    : 1.0 - initial release
// ============================================================================
interface minized_led_breather_if #(
    parameter int PWM_WIDTH = 8
);
    logic                 enable;
    logic                 mode;
    logic                 led_g;
    logic                 led_r;
    logic                 led_b;
    logic [PWM_WIDTH-1:0] duty;
    logic [2:0]           phase;

    modport master (
        output enable, mode,
        input  led_g, led_r, led_b, duty, phase
    );

    modport slave (
        input  enable, mode,
        output led_g, led_r, led_b, duty, phase
    );
endinterface
`default_nettype wire

// File: rtl/minized_led_breather_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm
//  Description : Free-running PWM counter and duty compare. The counter is
//                held at zero while disabled so every enable restarts a
//                clean PWM period.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pwm #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 enable,
    input  logic [PWM_WIDTH-1:0] eff_duty,
    output logic                 on
);

    logic [PWM_WIDTH-1:0] r_pwm_cnt;

    // PWM period counter: wraps at MAX, cleared while disabled
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_pwm_cnt <= '0;
        end else if (!enable) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end

    // Duty 0 is never on; MAX is on for all but the last count of the period
    assign on = (r_pwm_cnt < eff_duty);

endmodule
`default_nettype wire

// File: rtl/minized_led_breather.sv
`default_nettype none
// ============================================================================
//  Module      : minized_led_breather
//  Description : Green-up/down, gap, red-up/down, gap breathing sequence for
//                the MiniZed bicolor LED, with the blue DONE LED lit during
//                the gaps. LED outputs are registered once after the compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module minized_led_breather
    import minized_led_pkg::*;
#(
    parameter int PWM_WIDTH   = 8,
    parameter int STEP_CYCLES = 63725,
    parameter int OFF_STEPS   = 255
) (
    input  logic                           clk,
    input  logic                           rstN,
    minized_led_breather_if.slave          bus
);

    localparam int c_STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int c_OFF_W  = $clog2(OFF_STEPS) + 1;

    localparam logic [PWM_WIDTH-1:0] c_MAX       = '1;
    localparam logic [c_STEP_W-1:0]  c_STEP_LAST = c_STEP_W'(STEP_CYCLES - 1);
    localparam logic [c_OFF_W-1:0]   c_OFF_LAST  = c_OFF_W'(OFF_STEPS - 1);

    logic [c_STEP_W-1:0]  r_step_cnt;
    logic                 w_step;

    led_phase_t           r_state;
    led_phase_t           w_state_nxt;
    logic [PWM_WIDTH-1:0] r_duty;
    logic [PWM_WIDTH-1:0] w_duty_nxt;
    logic [c_OFF_W-1:0]   r_off_cnt;
    logic [c_OFF_W-1:0]   w_off_nxt;

    logic [PWM_WIDTH-1:0] w_eff_duty;
    logic                 w_on;
    logic                 w_led_g_d;
    logic                 w_led_r_d;
    logic                 w_led_b_d;
    logic                 r_led_g;
    logic                 r_led_r;
    logic                 r_led_b;

    // Brightness step timer; frozen at zero while disabled
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_step_cnt <= '0;
        end else if (!bus.enable || (r_step_cnt == c_STEP_LAST)) begin
            r_step_cnt <= '0;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
        end
    end

    assign w_step = bus.enable && (r_step_cnt == c_STEP_LAST);

    // Sequence state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= G_UP;
            r_duty    <= '0;
            r_off_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_duty    <= w_duty_nxt;
            r_off_cnt <= w_off_nxt;
        end
    end

    // Next-state logic: legal phases advance on a step, illegal codes recover at once
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_off_nxt   = r_off_cnt;
        case (r_state)
            G_UP, R_UP: begin
                if (w_step) begin
                    if (r_duty == c_MAX) begin
                        w_state_nxt = (r_state == G_UP) ? G_DN : R_DN;
                    end else begin
                        w_duty_nxt = r_duty + 1'b1;
                    end
                end
            end
            G_DN, R_DN: begin
                if (w_step) begin
                    if (r_duty == '0) begin
                        w_state_nxt = (r_state == G_DN) ? G_OFF : R_OFF;
                    end else begin
                        w_duty_nxt = r_duty - 1'b1;
                    end
                end
            end
            G_OFF, R_OFF: begin
                if (w_step) begin
                    if (r_off_cnt == c_OFF_LAST) begin
                        w_off_nxt   = '0;
                        w_state_nxt = (r_state == G_OFF) ? R_UP : G_UP;
                    end else begin
                        w_off_nxt = r_off_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = G_UP;
                w_duty_nxt  = '0;
                w_off_nxt   = '0;
            end
        endcase
    end

    // Output decode: hard-blink forces full brightness during ramps only
    always_comb begin
        w_eff_duty = (bus.mode && is_ramp(r_state)) ? c_MAX : r_duty;
        w_led_g_d  = bus.enable && is_green(r_state) && w_on;
        w_led_r_d  = bus.enable && is_red(r_state)   && w_on;
        w_led_b_d  = bus.enable && is_off(r_state);
    end

    led_pwm #(
        .PWM_WIDTH (PWM_WIDTH)
    ) u_pwm (
        .clk      (clk),
        .rstN     (rstN),
        .enable   (bus.enable),
        .eff_duty (w_eff_duty),
        .on       (w_on)
    );

    // LED drive registers, one clock behind the compare
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_led_g <= 1'b0;
            r_led_r <= 1'b0;
            r_led_b <= 1'b0;
        end else begin
            r_led_g <= w_led_g_d;
            r_led_r <= w_led_r_d;
            r_led_b <= w_led_b_d;
        end
    end

    assign bus.led_g = r_led_g;
    assign bus.led_r = r_led_r;
    assign bus.led_b = r_led_b;
    assign bus.duty  = r_duty;
    assign bus.phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_minized_led_breather.sv
`default_nettype none
// ============================================================================
//  Module      : tb_minized_led_breather
//  Description : Directed self-checking bench. u_dut uses STEP_CYCLES=2 for
//                sequence, freeze, reset and recovery checks; u_dut_s uses
//                STEP_CYCLES=16 so one duty level spans two PWM periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_minized_led_breather;
    import minized_led_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    logic rstN_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    minized_led_breather_if #(.PWM_WIDTH(3)) bus   ();
    minized_led_breather_if #(.PWM_WIDTH(3)) bus_s ();

    minized_led_breather #(
        .PWM_WIDTH   (3),
        .STEP_CYCLES (2),
        .OFF_STEPS   (2)
    ) u_dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    minized_led_breather #(
        .PWM_WIDTH   (3),
        .STEP_CYCLES (16),
        .OFF_STEPS   (2)
    ) u_dut_s (
        .clk  (clk),
        .rstN (rstN_s),
        .bus  (bus_s)
    );

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN       = 1'b0;
        bus.enable = 1'b1;
        bus.mode   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.led_g, bus.led_r, bus.led_b} !== 3'b000) begin
            errors++;
            $display("FAIL reset_leds got=%b exp=000", {bus.led_g, bus.led_r, bus.led_b});
        end
        checks++;
        if (bus.duty !== 3'd0) begin
            errors++;
            $display("FAIL reset_duty got=%0d exp=0", bus.duty);
        end
        checks++;
        if (bus.phase !== 3'd0) begin
            errors++;
            $display("FAIL reset_phase got=%0d exp=0", bus.phase);
        end
    endtask

    // One full 72-clock period plus two edges, checked at hand-picked edges
    task automatic test_full_cycle();
        logic [2:0] exp_ph;
        logic [2:0] exp_du;
        logic [2:0] exp_led;
        logic       chk_sd;
        logic       chk_led;
        rstN = 1'b1;
        for (int e = 1; e <= 74; e++) begin
            tick();
            chk_sd  = 1'b0;
            chk_led = 1'b0;
            exp_ph  = 3'd0;
            exp_du  = 3'd0;
            exp_led = 3'b000;
            case (e)
                1:  begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd0; end
                2:  begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd1; end
                9:  begin chk_led = 1'b1; exp_led = 3'b100; end
                14: begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd7; end
                15: begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd7;
                          chk_led = 1'b1; exp_led = 3'b100; end
                16: begin chk_sd = 1'b1; exp_ph = 3'd1; exp_du = 3'd7;
                          chk_led = 1'b1; exp_led = 3'b000; end
                18: begin chk_sd = 1'b1; exp_ph = 3'd1; exp_du = 3'd6; end
                30: begin chk_sd = 1'b1; exp_ph = 3'd1; exp_du = 3'd0; end
                32: begin chk_sd = 1'b1; exp_ph = 3'd2; exp_du = 3'd0; end
                33: begin chk_led = 1'b1; exp_led = 3'b001; end
                34: begin chk_sd = 1'b1; exp_ph = 3'd2; exp_du = 3'd0; end
                36: begin chk_sd = 1'b1; exp_ph = 3'd3; exp_du = 3'd0;
                          chk_led = 1'b1; exp_led = 3'b001; end
                37: begin chk_led = 1'b1; exp_led = 3'b000; end
                49: begin chk_led = 1'b1; exp_led = 3'b010; end
                50: begin chk_sd = 1'b1; exp_ph = 3'd3; exp_du = 3'd7; end
                52: begin chk_sd = 1'b1; exp_ph = 3'd4; exp_du = 3'd7; end
                66: begin chk_sd = 1'b1; exp_ph = 3'd4; exp_du = 3'd0; end
                68: begin chk_sd = 1'b1; exp_ph = 3'd5; exp_du = 3'd0; end
                70: begin chk_led = 1'b1; exp_led = 3'b001; end
                72: begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd0;
                          chk_led = 1'b1; exp_led = 3'b001; end
                73: begin chk_led = 1'b1; exp_led = 3'b000; end
                74: begin chk_sd = 1'b1; exp_ph = 3'd0; exp_du = 3'd1; end
                default: ;
            endcase
            if (chk_sd) begin
                checks++;
                if (bus.phase !== exp_ph || bus.duty !== exp_du) begin
                    errors++;
                    $display("FAIL full_cycle_state edge=%0d got phase=%0d duty=%0d exp phase=%0d duty=%0d",
                             e, bus.phase, bus.duty, exp_ph, exp_du);
                end
            end
            if (chk_led) begin
                checks++;
                if ({bus.led_g, bus.led_r, bus.led_b} !== exp_led) begin
                    errors++;
                    $display("FAIL full_cycle_leds edge=%0d got grb=%b exp grb=%b",
                             e, {bus.led_g, bus.led_r, bus.led_b}, exp_led);
                end
            end
        end
    endtask

    // Freeze in R_DN at duty 5 for 20 clocks, then resume
    task automatic test_enable_freeze();
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        repeat (56) tick();
        checks++;
        if (bus.phase !== 3'd4 || bus.duty !== 3'd5) begin
            errors++;
            $display("FAIL freeze_entry got phase=%0d duty=%0d exp phase=4 duty=5", bus.phase, bus.duty);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if ({bus.led_g, bus.led_r, bus.led_b} !== 3'b000 || bus.phase !== 3'd4 || bus.duty !== 3'd5) begin
            errors++;
            $display("FAIL freeze_first got grb=%b phase=%0d duty=%0d exp grb=000 phase=4 duty=5",
                     {bus.led_g, bus.led_r, bus.led_b}, bus.phase, bus.duty);
        end
        repeat (19) tick();
        checks++;
        if ({bus.led_g, bus.led_r, bus.led_b} !== 3'b000 || bus.phase !== 3'd4 || bus.duty !== 3'd5) begin
            errors++;
            $display("FAIL freeze_hold got grb=%b phase=%0d duty=%0d exp grb=000 phase=4 duty=5",
                     {bus.led_g, bus.led_r, bus.led_b}, bus.phase, bus.duty);
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.duty !== 3'd5) begin
            errors++;
            $display("FAIL resume_no_step got duty=%0d exp=5", bus.duty);
        end
        tick();
        checks++;
        if (bus.phase !== 3'd4 || bus.duty !== 3'd4) begin
            errors++;
            $display("FAIL resume_step got phase=%0d duty=%0d exp phase=4 duty=4", bus.phase, bus.duty);
        end
    endtask

    // Asynchronous reset between clock edges while in R_DN
    task automatic test_async_reset();
        tick();
        rstN = 1'b0;
        #1;
        checks++;
        if ({bus.led_g, bus.led_r, bus.led_b} !== 3'b000 || bus.phase !== 3'd0 || bus.duty !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got grb=%b phase=%0d duty=%0d exp grb=000 phase=0 duty=0",
                     {bus.led_g, bus.led_r, bus.led_b}, bus.phase, bus.duty);
        end
        tick();
        rstN = 1'b1;
        tick();
        checks++;
        if (bus.phase !== 3'd0 || bus.duty !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_first got phase=%0d duty=%0d exp phase=0 duty=0", bus.phase, bus.duty);
        end
        tick();
        checks++;
        if (bus.phase !== 3'd0 || bus.duty !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_step got phase=%0d duty=%0d exp phase=0 duty=1", bus.phase, bus.duty);
        end
    endtask

    // Illegal phase code recovers to G_UP with duty 0 on the next clock
    task automatic test_illegal_state();
        repeat (2) tick();
        force u_dut.r_state = led_phase_t'(3'd7);
        #1;
        release u_dut.r_state;
        tick();
        checks++;
        if (bus.phase !== 3'd0 || bus.duty !== 3'd0) begin
            errors++;
            $display("FAIL illegal_recover got phase=%0d duty=%0d exp phase=0 duty=0", bus.phase, bus.duty);
        end
    endtask

    // Duty 3 held for 16 clocks: green on 3 of 8, one clock after pwm 0,1,2
    task automatic test_pwm_duty();
        int highs;
        highs          = 0;
        bus_s.enable   = 1'b1;
        bus_s.mode     = 1'b0;
        rstN_s         = 1'b0;
        tick();
        rstN_s = 1'b1;
        for (int e = 1; e <= 56; e++) begin
            tick();
            if (e == 48) begin
                checks++;
                if (bus_s.phase !== 3'd0 || bus_s.duty !== 3'd3) begin
                    errors++;
                    $display("FAIL pwm_duty_level got phase=%0d duty=%0d exp phase=0 duty=3",
                             bus_s.phase, bus_s.duty);
                end
            end
            if (e >= 49) begin
                highs += int'(bus_s.led_g);
                checks++;
                if (bus_s.led_g !== (e <= 51) || bus_s.led_r !== 1'b0) begin
                    errors++;
                    $display("FAIL pwm_duty_bit edge=%0d got g=%b r=%b exp g=%b r=0",
                             e, bus_s.led_g, bus_s.led_r, (e <= 51));
                end
            end
        end
        checks++;
        if (highs != 3) begin
            errors++;
            $display("FAIL pwm_duty_count got=%0d exp=3", highs);
        end
    endtask

    // Hard blink at duty 1: green on 7 of 8, duty still advances per step
    task automatic test_hard_blink();
        int highs;
        highs      = 0;
        rstN_s     = 1'b0;
        bus_s.mode = 1'b1;
        tick();
        rstN_s = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e == 17) begin
                checks++;
                if (bus_s.duty !== 3'd1) begin
                    errors++;
                    $display("FAIL blink_duty1 got=%0d exp=1", bus_s.duty);
                end
            end
            if (e >= 17 && e <= 24) begin
                highs += int'(bus_s.led_g);
                checks++;
                if (bus_s.led_g !== (e != 24)) begin
                    errors++;
                    $display("FAIL blink_bit edge=%0d got g=%b exp g=%b", e, bus_s.led_g, (e != 24));
                end
            end
            if (e == 33) begin
                checks++;
                if (bus_s.phase !== 3'd0 || bus_s.duty !== 3'd2) begin
                    errors++;
                    $display("FAIL blink_duty2 got phase=%0d duty=%0d exp phase=0 duty=2",
                             bus_s.phase, bus_s.duty);
                end
            end
        end
        checks++;
        if (highs != 7) begin
            errors++;
            $display("FAIL blink_count got=%0d exp=7", highs);
        end
        bus_s.mode = 1'b0;
    endtask

    initial begin
        rstN_s       = 1'b0;
        bus_s.enable = 1'b0;
        bus_s.mode   = 1'b0;
        test_reset();
        test_full_cycle();
        test_enable_freeze();
        test_async_reset();
        test_illegal_state();
        test_pwm_duty();
        test_hard_blink();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
